// File: rtl/ram_256_16bit_reader_pkg.sv
// -----------------------------------------------------------------------------
// grb_ram_pkg
// Shared definitions for the 256x16 block-RAM buffer and its readout engine.
//   RAM_ADDR_W / RAM_DATA_W / RAM_DEPTH : geometry of the bin RAM
//   rd_state_e                          : readout FSM state encoding
//   pick_byte()                         : selects the high or low byte of a word
// -----------------------------------------------------------------------------
package grb_ram_pkg;

  localparam int unsigned RAM_ADDR_W = 8;
  localparam int unsigned RAM_DATA_W = 16;
  localparam int unsigned RAM_DEPTH  = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_SEND_A,
    ST_SEND_B
  } rd_state_e;

  // hi=1 returns word[15:8], hi=0 returns word[7:0]
  function automatic logic [7:0] pick_byte(input logic [RAM_DATA_W-1:0] word,
                                           input logic                  hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage : grb_ram_pkg

// File: rtl/ram_256_16bit_reader_if.sv
// -----------------------------------------------------------------------------
// ram_256_16bit_reader_if
// Bundles the RAM read/write port and the outgoing byte stream of the readout
// engine.
//   RAM side   : ram_raddr, ram_dout, ram_waddr, ram_din, ram_we
//   Stream side: out_data, out_valid, out_ready
// Modports:
//   master : the readout engine (drives addresses, write port, stream)
//   slave  : the environment (RAM + downstream framer)
// -----------------------------------------------------------------------------
interface ram_256_16bit_reader_if
  import grb_ram_pkg::*;
();

  logic [RAM_ADDR_W-1:0] ram_raddr;
  logic [RAM_DATA_W-1:0] ram_dout;
  logic [RAM_ADDR_W-1:0] ram_waddr;
  logic [RAM_DATA_W-1:0] ram_din;
  logic                  ram_we;
  logic [7:0]            out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output ram_raddr,
    output ram_waddr,
    output ram_din,
    output ram_we,
    output out_data,
    output out_valid,
    input  ram_dout,
    input  out_ready
  );

  modport slave (
    input  ram_raddr,
    input  ram_waddr,
    input  ram_din,
    input  ram_we,
    input  out_data,
    input  out_valid,
    output ram_dout,
    output out_ready
  );

endinterface : ram_256_16bit_reader_if

// File: rtl/ram_256_16bit_reader.sv
// -----------------------------------------------------------------------------
// ram_256_16bit_reader
// Readout engine for the 256x16 bin RAM. On a start pulse it walks addresses
// 0..NUM_WORDS-1 through the synchronous RAM read port and serialises each
// 16-bit word as two bytes on a valid/ready byte stream.
//
// Parameters:
//   NUM_WORDS : words read per run (1..256)
//   MSB_FIRST : 1 = high byte of each word first, 0 = low byte first
//
// Ports:
//   clk   : single clock (same as RAM read/write clock)
//   rst_n : asynchronous active-low reset
//   start : one-cycle request to begin a run (ignored while busy)
//   busy  : run in progress; upstream writer must hold off RAM writes
//   done  : one-cycle pulse after the last byte is accepted
//   bus   : RAM port + byte stream (ram_256_16bit_reader_if.master)
//
// Build option:
//   RAM_READER_CLEAR_ON_READ_EN : when defined, each bin is written to zero
//   in the cycle its read data is captured (clear-on-read). When undefined the
//   RAM write port is tied off.
// -----------------------------------------------------------------------------
module ram_256_16bit_reader
  import grb_ram_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 256,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  ram_256_16bit_reader_if.master bus
);

  localparam logic [RAM_ADDR_W-1:0] LAST_ADDR = RAM_ADDR_W'(NUM_WORDS - 1);
  localparam logic                  HI_FIRST  = (MSB_FIRST != 0);

  rd_state_e             state_q, state_d;
  logic [RAM_ADDR_W-1:0] addr_q,  addr_d;
  logic [RAM_ADDR_W-1:0] raddr_q, raddr_d;
  logic [RAM_DATA_W-1:0] word_q,  word_d;
  logic [7:0]            data_q,  data_d;
  logic                  valid_q, valid_d;
  logic                  busy_q,  busy_d;
  logic                  done_q,  done_d;

  logic accept;
  logic last_word;

  assign accept    = valid_q && bus.out_ready;
  assign last_word = (addr_q == LAST_ADDR);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      raddr_q <= '0;
      word_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      raddr_q <= raddr_d;
      word_q  <= word_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_LATCH;
      ST_LATCH:  state_d = ST_SEND_A;
      ST_SEND_A: if (accept) state_d = ST_SEND_B;
      ST_SEND_B: if (accept) state_d = last_word ? ST_IDLE : ST_FETCH;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    addr_d  = addr_q;
    raddr_d = raddr_q;
    word_d  = word_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = '0;
          raddr_d = '0;
          busy_d  = 1'b1;
        end
      end
      ST_FETCH: begin
        // RAM samples raddr_q at the end of this cycle
      end
      ST_LATCH: begin
        word_d  = bus.ram_dout;
        data_d  = pick_byte(bus.ram_dout, HI_FIRST);
        valid_d = 1'b1;
      end
      ST_SEND_A: begin
        if (accept) data_d = pick_byte(word_q, !HI_FIRST);
      end
      ST_SEND_B: begin
        if (accept) begin
          valid_d = 1'b0;
          if (last_word) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            addr_d  = addr_q + 1'b1;
            raddr_d = addr_q + 1'b1;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // RAM write port (clear-on-read)
  // ---------------------------------------------------------------------------
`ifdef RAM_READER_CLEAR_ON_READ_EN
  // The read of addr_q completed in FETCH; zeroing it in LATCH lands on the
  // same edge that captures the word, so the stored value is never lost.
  logic clr_we;
  always_comb begin
    clr_we        = (state_q == ST_LATCH);
    bus.ram_we    = clr_we;
    bus.ram_waddr = clr_we ? addr_q : '0;
    bus.ram_din   = '0;
  end
`else
  assign bus.ram_we    = 1'b0;
  assign bus.ram_waddr = '0;
  assign bus.ram_din   = '0;
`endif

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.ram_raddr = raddr_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;

endmodule : ram_256_16bit_reader

// File: tb/tb_ram_256_16bit_reader.sv
// -----------------------------------------------------------------------------
// tb_ram_256_16bit_reader
// Bench for ram_256_16bit_reader. Four instances:
//   A: NUM_WORDS=4,   MSB_FIRST=1   B: NUM_WORDS=4, MSB_FIRST=0
//   C: NUM_WORDS=256, MSB_FIRST=1   D: NUM_WORDS=1, MSB_FIRST=1
// Each has its own synchronous RAM model preloaded with 16'hA500+i.
// -----------------------------------------------------------------------------
module tb_ram_256_16bit_reader;
  import grb_ram_pkg::*;

`ifdef RAM_READER_CLEAR_ON_READ_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic [3:0] st;
  logic [3:0] rdy;
  logic [3:0] load;
  logic busy_a, busy_b, busy_c, busy_d;
  logic done_a, done_b, done_c, done_d;
  logic [3:0] busy_v, done_v, valid_v;

  int n_chk = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ram_256_16bit_reader_if ifa();
  ram_256_16bit_reader_if ifb();
  ram_256_16bit_reader_if ifc();
  ram_256_16bit_reader_if ifd();

  ram_256_16bit_reader #(.NUM_WORDS(4), .MSB_FIRST(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .busy(busy_a), .done(done_a), .bus(ifa));
  ram_256_16bit_reader #(.NUM_WORDS(4), .MSB_FIRST(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .busy(busy_b), .done(done_b), .bus(ifb));
  ram_256_16bit_reader #(.NUM_WORDS(256), .MSB_FIRST(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .busy(busy_c), .done(done_c), .bus(ifc));
  ram_256_16bit_reader #(.NUM_WORDS(1), .MSB_FIRST(1)) u_d (
    .clk(clk), .rst_n(rst_n), .start(st[3]), .busy(busy_d), .done(done_d), .bus(ifd));

  assign busy_v  = {busy_d, busy_c, busy_b, busy_a};
  assign done_v  = {done_d, done_c, done_b, done_a};
  assign valid_v = {ifd.out_valid, ifc.out_valid, ifb.out_valid, ifa.out_valid};
  assign ifa.out_ready = rdy[0];
  assign ifb.out_ready = rdy[1];
  assign ifc.out_ready = rdy[2];
  assign ifd.out_ready = rdy[3];

  // RAM models: synchronous read, write port, bulk preload on request
  logic [15:0] mem_a [RAM_DEPTH];
  logic [15:0] mem_b [RAM_DEPTH];
  logic [15:0] mem_c [RAM_DEPTH];
  logic [15:0] mem_d [RAM_DEPTH];
  logic [15:0] dout_a, dout_b, dout_c, dout_d;
  assign ifa.ram_dout = dout_a;
  assign ifb.ram_dout = dout_b;
  assign ifc.ram_dout = dout_c;
  assign ifd.ram_dout = dout_d;

  always @(posedge clk) begin
    if (load[0]) for (int i = 0; i < RAM_DEPTH; i++) mem_a[i] <= 16'hA500 + 16'(i);
    else if (ifa.ram_we) mem_a[ifa.ram_waddr] <= ifa.ram_din;
    dout_a <= mem_a[ifa.ram_raddr];
  end
  always @(posedge clk) begin
    if (load[1]) for (int i = 0; i < RAM_DEPTH; i++) mem_b[i] <= 16'hA500 + 16'(i);
    else if (ifb.ram_we) mem_b[ifb.ram_waddr] <= ifb.ram_din;
    dout_b <= mem_b[ifb.ram_raddr];
  end
  always @(posedge clk) begin
    if (load[2]) for (int i = 0; i < RAM_DEPTH; i++) mem_c[i] <= 16'hA500 + 16'(i);
    else if (ifc.ram_we) mem_c[ifc.ram_waddr] <= ifc.ram_din;
    dout_c <= mem_c[ifc.ram_raddr];
  end
  always @(posedge clk) begin
    if (load[3]) for (int i = 0; i < RAM_DEPTH; i++) mem_d[i] <= 16'hA500 + 16'(i);
    else if (ifd.ram_we) mem_d[ifd.ram_waddr] <= ifd.ram_din;
    dout_d <= mem_d[ifd.ram_raddr];
  end

  // Accepted-byte logs
  logic [7:0] qa[$], qb[$], qc[$], qd[$];
  always @(posedge clk) if (ifa.out_valid && ifa.out_ready) qa.push_back(ifa.out_data);
  always @(posedge clk) if (ifb.out_valid && ifb.out_ready) qb.push_back(ifb.out_data);
  always @(posedge clk) if (ifc.out_valid && ifc.out_ready) qc.push_back(ifc.out_data);
  always @(posedge clk) if (ifd.out_valid && ifd.out_ready) qd.push_back(ifd.out_data);

  // Write-pulse monitor for instance C: expected address follows the pulse count
  int we_cnt_c = 0;
  int we_bad_c = 0;
  logic we_prev_c = 1'b0;
  always @(posedge clk) begin
    we_prev_c <= ifc.ram_we;
    if (ifc.ram_we) begin
      we_cnt_c <= we_cnt_c + 1;
      if (ifc.ram_waddr != 8'(we_cnt_c) || ifc.ram_din != 16'h0 || we_prev_c)
        we_bad_c <= we_bad_c + 1;
    end
  end

  typedef struct {
    logic       start;
    logic       rdy;
    logic       busy;
    logic       done;
    logic       valid;
    logic       chk_data;
    logic [7:0] data;
    logic [7:0] raddr;
    logic       latch;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0: return qa.size();
      1: return qb.size();
      2: return qc.size();
      default: return qd.size();
    endcase
  endfunction

  function automatic logic [7:0] qbyte(input int d, input int i);
    case (d)
      0: return qa[i];
      1: return qb[i];
      2: return qc[i];
      default: return qd[i];
    endcase
  endfunction

  function automatic logic [7:0] get_data(input int d);
    case (d)
      0: return ifa.out_data;
      1: return ifb.out_data;
      2: return ifc.out_data;
      default: return ifd.out_data;
    endcase
  endfunction

  function automatic logic [7:0] get_raddr(input int d);
    case (d)
      0: return ifa.ram_raddr;
      1: return ifb.ram_raddr;
      2: return ifc.ram_raddr;
      default: return ifd.ram_raddr;
    endcase
  endfunction

  function automatic logic [24:0] get_wport(input int d);
    case (d)
      0: return {ifa.ram_we, ifa.ram_waddr, ifa.ram_din};
      1: return {ifb.ram_we, ifb.ram_waddr, ifb.ram_din};
      2: return {ifc.ram_we, ifc.ram_waddr, ifc.ram_din};
      default: return {ifd.ram_we, ifd.ram_waddr, ifd.ram_din};
    endcase
  endfunction

  // Expected i-th byte of a run over RAM[w]=16'hA500+w
  function automatic logic [7:0] eb(input int i, input bit msb, input bit cleared);
    logic [7:0] w;
    w = 8'(i / 2);
    if (cleared) return 8'h00;
    if ((i % 2 == 0) == msb) return 8'hA5;
    return w;
  endfunction

  task automatic chk_zero(input int d, input string tag);
    chk($sformatf("%s_busy%0d", tag, d), busy_v[d], 1'b0);
    chk($sformatf("%s_done%0d", tag, d), done_v[d], 1'b0);
    chk($sformatf("%s_valid%0d", tag, d), valid_v[d], 1'b0);
    chk($sformatf("%s_data%0d", tag, d), get_data(d), 8'h00);
    chk($sformatf("%s_raddr%0d", tag, d), get_raddr(d), 8'h00);
    chk($sformatf("%s_wport%0d", tag, d), get_wport(d), 25'h0);
  endtask

  task automatic reload(input int d);
    load[d] = 1'b1;
    @(negedge clk);
    load[d] = 1'b0;
  endtask

  // Wait at negedges until done is seen; n = edges waited (0 = already high)
  task automatic wait_done(input int d, input int budget, output int n);
    n = 0;
    while (!done_v[d] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("done_timeout%0d", d), (n < budget), 1'b1);
  endtask

  // Pulse start (sampled at edge 0); returns index of the edge after which done is high
  task automatic run(input int d, input int budget, output int edge_n);
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
    wait_done(d, budget, edge_n);
  endtask

  task automatic wait_bytes(input int d, input int target, input int budget);
    int n = 0;
    while (qsize(d) < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("bytes_timeout%0d", d), (n < budget), 1'b1);
  endtask

  task automatic chk_bytes(input int d, input string tag, input int base, input int cnt,
                           input bit msb, input bit cleared);
    int bad = 0;
    chk($sformatf("%s_count", tag), qsize(d) - base, cnt);
    if (qsize(d) - base >= cnt)
      for (int i = 0; i < cnt; i++)
        if (qbyte(d, base + i) !== eb(i, msb, cleared)) begin
          if (bad == 0)
            $display("FAIL %s_byte%0d: got %0h expected %0h", tag, i,
                     qbyte(d, base + i), eb(i, msb, cleared));
          bad++;
        end
    chk($sformatf("%s_bad_bytes", tag), bad, 0);
  endtask

  initial begin
    int base, e, n;
    bit seen;

    // Cycle table for instance A, out_ready high: row k = state after edge k
    for (int w = 0; w < 4; w++) begin
      tbl[4*w]   = '{(w == 0), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'(w), 1'b0};
      tbl[4*w+1] = '{1'b0,     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'(w), 1'b1};
      tbl[4*w+2] = '{1'b0,     1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 8'(w), 1'b0};
      tbl[4*w+3] = '{1'b0,     1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'(w), 8'(w), 1'b0};
    end
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0};

    // Reset state
    rst_n = 1'b0;
    st    = '0;
    rdy   = '0;
    load  = '0;
    #1;
    for (int d = 0; d < 4; d++) chk_zero(d, "reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rdy   = 4'b1110;
    load  = 4'hF;
    @(negedge clk);
    load  = '0;

    // Table-driven run on A: latency, byte order, done timing, busy
    for (int k = 0; k < 18; k++) begin
      st[0]  = tbl[k].start;
      rdy[0] = tbl[k].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_busy", k), busy_a, tbl[k].busy);
      chk($sformatf("tbl%0d_done", k), done_a, tbl[k].done);
      chk($sformatf("tbl%0d_valid", k), ifa.out_valid, tbl[k].valid);
      if (tbl[k].chk_data) chk($sformatf("tbl%0d_data", k), ifa.out_data, tbl[k].data);
      chk($sformatf("tbl%0d_raddr", k), ifa.ram_raddr, tbl[k].raddr);
      chk($sformatf("tbl%0d_we", k), ifa.ram_we, CLR && tbl[k].latch);
      chk($sformatf("tbl%0d_waddr", k), ifa.ram_waddr,
          (CLR && tbl[k].latch) ? tbl[k].raddr : 8'h00);
      chk($sformatf("tbl%0d_din", k), ifa.ram_din, 16'h0);
    end
    chk_bytes(0, "tblA", 0, 8, 1'b1, 1'b0);

    // LSB-first ordering on B
    base = qb.size();
    run(1, 60, e);
    chk("lsb_done_edge", e, 16);
    chk_bytes(1, "lsb", base, 8, 1'b0, 1'b0);

    // Ten-cycle stall in SEND_A of word 2 on A
    reload(0);
    base = qa.size();
    rdy[0] = 1'b1;
    st[0]  = 1'b1;
    @(negedge clk);
    st[0]  = 1'b0;
    wait_bytes(0, base + 4, 40);
    rdy[0] = 1'b0;
    n = 0;
    while (!ifa.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid_timeout", (n < 20), 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", c), ifa.out_valid, 1'b1);
      chk($sformatf("stall%0d_data", c), ifa.out_data, 8'hA5);
    end
    chk("stall_no_accept", qa.size() - base, 4);
    rdy[0] = 1'b1;
    wait_done(0, 60, e);
    chk_bytes(0, "stall", base, 8, 1'b1, 1'b0);

    // start while busy is ignored; start coincident with done begins a new run
    reload(0);
    base = qa.size();
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (5) @(negedge clk);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    chk("busy_start_busy", busy_a, 1'b1);
    wait_done(0, 60, e);
    chk("busy_low_with_done", busy_a, 1'b0);
    chk_bytes(0, "run1", base, 8, 1'b1, 1'b0);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    chk("restart_busy", busy_a, 1'b1);
    chk("restart_raddr", ifa.ram_raddr, 8'h00);
    wait_done(0, 60, e);
    chk_bytes(0, "run2", base + 8, 8, 1'b1, CLR);
    repeat (6) @(negedge clk);
    chk("no_queued_run_busy", busy_a, 1'b0);
    chk("no_queued_run_bytes", qa.size() - base, 16);

    // Reset during SEND_B of word 1
    reload(0);
    base = qa.size();
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    wait_bytes(0, base + 3, 40);
    rdy[0] = 1'b0;
    chk("pre_reset_valid", ifa.out_valid, 1'b1);
    chk("pre_reset_data", ifa.out_data, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk_zero(0, "midrst");
    @(negedge clk);
    rst_n  = 1'b1;
    rdy[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done_a) seen = 1'b1;
    end
    chk("midrst_no_done", seen, 1'b0);
    chk("midrst_bytes", qa.size() - base, 3);
    reload(0);
    base = qa.size();
    run(0, 60, e);
    chk("after_rst_done_edge", e, 16);
    chk_bytes(0, "after_rst", base, 8, 1'b1, 1'b0);

    // NUM_WORDS=256: full address range, clear-on-read pulses, second run
    base = qc.size();
    n = we_cnt_c;
    run(2, 1100, e);
    chk("full_done_edge", e, 1024);
    chk("full_last_raddr", ifc.ram_raddr, 8'hFF);
    chk("full_we_count", we_cnt_c - n, CLR ? 256 : 0);
    chk("full_we_bad", we_bad_c, 0);
    chk_bytes(2, "full1", base, 512, 1'b1, 1'b0);
    base = qc.size();
    run(2, 1100, e);
    chk("full2_done_edge", e, 1024);
    chk_bytes(2, "full2", base, 512, 1'b1, CLR);

    // NUM_WORDS=1: exactly one word
    base = qd.size();
    run(3, 40, e);
    chk("one_done_edge", e, 4);
    chk_bytes(3, "one", base, 2, 1'b1, 1'b0);
    chk("one_raddr", ifd.ram_raddr, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_ram_256_16bit_reader
